// File: rtl/seq_multdiv_n.sv
// Sequential signed multiply/divide, one bit per cycle, WIDTH generic.
// Ports: clock, reset_n, data_operandA/B, ctrl_MULT/DIV in; data_result,
// data_result_hi, data_exception, data_resultRDY out. Macro: MULTDIV_HI_EN.
module seq_multdiv_n #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [WIDTH-1:0] MIN_INT =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  // multiply: {hi, lo} partial product; divide: {rem, quotient}
  logic [2*WIDTH-1:0] acc;

  logic               start;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  assign start    = ctrl_MULT ^ ctrl_DIV;
  assign in_mag_a = data_operandA[WIDTH-1] ?
                    -data_operandA : data_operandA;
  assign in_mag_b = data_operandB[WIDTH-1] ?
                    -data_operandB : data_operandB;

  // shift-add step, carry kept so the product never wraps
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_next = {add_sum, acc[WIDTH-1:1]};

  // restoring step on magnitudes
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, mag_b};
  assign div_next = {div_diff[WIDTH] ?
                     div_sh[WIDTH-1:0] :
                     div_diff[WIDTH-1:0],
                     acc[WIDTH-2:0], ~div_diff[WIDTH]};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix;
  logic               b_zero;
  logic               ovf_div;
  logic [WIDTH-1:0]   fix_res;
  logic               fix_exc;

  assign prod    = (sign_a ^ sign_b) ? -acc : acc;
  assign q_fix   = (sign_a ^ sign_b) ?
                   -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign b_zero  = (mag_b == '0);
  assign ovf_div = sign_a && (mag_a == MIN_INT) &&
                   sign_b && (mag_b == WIDTH'(1));

`ifdef MULTDIV_HI_EN
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] fix_hi;

  assign r_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] :
                  acc[2*WIDTH-1:WIDTH];
  assign a_orig = sign_a ? -mag_a : mag_a;
`endif

  always_comb begin
    fix_res = '0;
    fix_exc = 1'b0;
`ifdef MULTDIV_HI_EN
    fix_hi  = '0;
`endif
    if (!is_div) begin
      fix_res = prod[WIDTH-1:0];
      fix_exc = prod[2*WIDTH-1:WIDTH] !=
                {WIDTH{prod[WIDTH-1]}};
`ifdef MULTDIV_HI_EN
      fix_hi  = prod[2*WIDTH-1:WIDTH];
`endif
    end else if (b_zero) begin
      fix_res = '0;
      fix_exc = 1'b1;
`ifdef MULTDIV_HI_EN
      fix_hi  = a_orig;
`endif
    end else begin
      // MIN_INT / -1 lands on MIN_INT naturally
      fix_res = q_fix;
      fix_exc = ovf_div;
`ifdef MULTDIV_HI_EN
      fix_hi  = r_fix;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      is_div         <= 1'b0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      mag_a          <= '0;
      mag_b          <= '0;
      acc            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state  <= RUN;
        cnt    <= '0;
        is_div <= ctrl_DIV;
        sign_a <= data_operandA[WIDTH-1];
        sign_b <= data_operandB[WIDTH-1];
        mag_a  <= in_mag_a;
        mag_b  <= in_mag_b;
        acc    <= {{WIDTH{1'b0}},
                   ctrl_DIV ? in_mag_a : in_mag_b};
      end else begin
        unique case (state)
          RUN: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST)
              state <= FIX;
          end
          FIX: begin
            data_result    <= fix_res;
            data_exception <= fix_exc;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MULTDIV_HI_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      data_result_hi <= '0;
    else if (!start && state == FIX)
      data_result_hi <= fix_hi;
  end
`else
  assign data_result_hi = '0;
`endif

endmodule

// File: tb/tb_seq_multdiv_n.sv
// Scoreboard bench for seq_multdiv_n at WIDTH=32 and WIDTH=8.
// Expectations are hand-computed; monitors pop on each RDY pulse.
module tb_seq_multdiv_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] a32 = '0, b32 = '0;
  logic        m32 = 1'b0, d32 = 1'b0;
  logic [31:0] res32, hi32;
  logic        exc32, rdy32;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        m8 = 1'b0, d8 = 1'b0;
  logic [7:0]  res8, hi8;
  logic        exc8, rdy8;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multdiv_n #(.WIDTH(32)) u32 (
    .clock(clk), .reset_n(rst_n),
    .data_operandA(a32), .data_operandB(b32),
    .ctrl_MULT(m32), .ctrl_DIV(d32),
    .data_result(res32), .data_result_hi(hi32),
    .data_exception(exc32), .data_resultRDY(rdy32)
  );

  seq_multdiv_n #(.WIDTH(8)) u8 (
    .clock(clk), .reset_n(rst_n),
    .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(m8), .ctrl_DIV(d8),
    .data_result(res8), .data_result_hi(hi8),
    .data_exception(exc8), .data_resultRDY(rdy8)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hx(input logic [31:0] v);
`ifdef MULTDIV_HI_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rdy32) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdy32_unexpected: got 1, want 0 at cyc %0d", cyc);
      end else begin
        e = q32.pop_front();
        check("res32", 64'(res32), 64'(e.res));
        check("hi32", 64'(hi32), 64'(e.hi));
        check("exc32", 64'(exc32), 64'(e.exc));
        check("lat32", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rdy8) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdy8_unexpected: got 1, want 0 at cyc %0d", cyc);
      end else begin
        e = q8.pop_front();
        check("res8", 64'(res8), 64'(e.res[7:0]));
        check("hi8", 64'(hi8), 64'(e.hi[7:0]));
        check("exc8", 64'(exc8), 64'(e.exc));
        check("lat8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic go32(input bit div, input logic [31:0] a,
                      input logic [31:0] b, input bit push,
                      input logic [31:0] er, input logic [31:0] eh,
                      input logic ee);
    exp_t e;
    @(posedge clk); #1;
    a32 = a; b32 = b; m32 = !div; d32 = div;
    @(posedge clk); #1;
    m32 = 1'b0; d32 = 1'b0; a32 = '1; b32 = '1;
    if (push) begin
      e.res = er; e.hi = hx(eh); e.exc = ee; e.cyc = cyc + 33;
      q32.push_back(e);
    end
  endtask

  task automatic go8(input bit div, input logic [7:0] a,
                     input logic [7:0] b, input bit push,
                     input logic [7:0] er, input logic [7:0] eh,
                     input logic ee);
    exp_t e;
    @(posedge clk); #1;
    a8 = a; b8 = b; m8 = !div; d8 = div;
    @(posedge clk); #1;
    m8 = 1'b0; d8 = 1'b0; a8 = '1; b8 = '1;
    if (push) begin
      e.res = {24'h0, er}; e.hi = hx({24'h0, eh});
      e.exc = ee; e.cyc = cyc + 9;
      q8.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && (q32.size() + q8.size()) > 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", 64'(q32.size() + q8.size()), 64'(0));
  endtask

  initial begin
    #2;
    check("rst_res32", 64'(res32), 64'(0));
    check("rst_exc32", 64'(exc32), 64'(0));
    check("rst_rdy32", 64'(rdy32), 64'(0));
    check("rst_hi8", 64'(hi8), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    go32(0, 32'd2, -32'sd4, 1, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);
    drain();
    go32(0, 32'h10000, 32'h10000, 1, 32'h0, 32'h1, 1);
    drain();
    go32(1, -32'sd7, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    drain();
    go32(1, 32'd5, 32'd0, 1, 32'h0, 32'd5, 1);
    drain();

    // restart mid-run, then a both-high edge that must be ignored
    go32(0, 32'd3, 32'd5, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    go32(1, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0);
    repeat (5) @(posedge clk);
    @(posedge clk); #1;
    a32 = 32'd9; b32 = 32'd9; m32 = 1'b1; d32 = 1'b1;
    @(posedge clk); #1;
    m32 = 1'b0; d32 = 1'b0;
    drain();

    // back-to-back: second start on the RDY cycle
    go32(1, -32'sd100, 32'd7, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    repeat (32) @(posedge clk);
    go32(1, 32'd100, -32'sd7, 1, 32'hFFFFFFF2, 32'd2, 0);
    drain();
    go32(1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0, 1);
    drain();

    // async reset mid-operation
    go32(0, 32'd3, 32'd5, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_res32", 64'(res32), 64'(0));
    check("arst_exc32", 64'(exc32), 64'(0));
    check("arst_rdy32", 64'(rdy32), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    go32(0, 32'd2, -32'sd4, 1, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);
    drain();

    go8(1, 8'h80, 8'hFF, 1, 8'h80, 8'h00, 1);
    drain();
    go8(0, 8'h80, 8'hFF, 1, 8'h80, 8'h00, 1);
    drain();
    go8(0, 8'd7, 8'hFD, 1, 8'hEB, 8'hFF, 0);
    drain();
    go8(0, 8'd127, 8'd2, 1, 8'hFE, 8'h00, 1);
    drain();
    // start on the FIX edge aborts the finishing op
    go8(0, 8'd5, 8'd5, 0, 0, 0, 0);
    repeat (7) @(posedge clk);
    go8(0, 8'd3, 8'd3, 1, 8'd9, 8'd0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multdiv_n.md
# seq_multdiv_n

Parametrised sequential signed multiplier/divider, the WIDTH-generic successor of the fixed 32-bit multdiv unit; it sits beside the ALU in the execute stage and is driven by the same single-cycle ctrl_MULT/ctrl_DIV start pulses. It iterates one bit per cycle (shift-add multiply, restoring divide on magnitudes, sign fix-up at the end), flags overflow and divide-by-zero, supports restart while busy, and signals completion with a one-cycle data_resultRDY pulse.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.
- clock  input  1  sole clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement.
- data_operandB  input  WIDTH  multiplier / divisor, two's complement.
- ctrl_MULT  input  1  start multiply; sampled each rising edge.
- ctrl_DIV  input  1  start divide; sampled each rising edge.
- data_result  output  WIDTH  product low half / quotient.
- data_result_hi  output  WIDTH  product high half / remainder (see Configuration).
- data_exception  output  1  overflow or divide-by-zero for the current result.
- data_resultRDY  output  1  one-cycle pulse: result outputs are newly valid.

## Operation
- States: IDLE, RUN, FIX. Reset (reset_n=0, any time, no clock needed): state IDLE, counter 0, all outputs and internal datapath registers 0.
- Start: an edge with exactly one of ctrl_MULT/ctrl_DIV high latches both operands, op type, and operand signs, stores magnitudes, clears the counter, and moves to RUN. This happens from any state; a start in RUN or FIX aborts the operation in flight, with no RDY pulse for it.
- Both ctrl_MULT and ctrl_DIV high on one edge: illegal. It is ignored, and the current state and operation continue unaffected.
- RUN: one iteration per edge; counter increments; after WIDTH iterations the state moves to FIX.
- FIX: one edge. It applies the sign, writes data_result/data_result_hi/data_exception, pulses data_resultRDY, and returns to IDLE.
- Multiply: the 2*WIDTH signed product P is formed. data_result = P[WIDTH-1:0]. data_exception=1 iff P is not the sign extension of P[WIDTH-1:0].
- Divide: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divisor 0: data_result=0, data_result_hi=dividend, exception=1, normal latency.
- Dividend MIN_INT with divisor -1: data_result=MIN_INT, data_result_hi=0, exception=1.
- Result outputs hold their last written values until the next FIX or reset; they are not cleared on start.
- Operand inputs are ignored except on the start edge.

## Timing
- Start edge = edge 0. Iterations occur on edges 1..WIDTH. FIX occurs on edge WIDTH+1.
- data_resultRDY is high from edge WIDTH+1 to edge WIDTH+2 (exactly one cycle). Latency is WIDTH+1 cycles start-to-RDY; for WIDTH=32 this is 33 cycles.
- data_result, data_result_hi and data_exception change only on the FIX edge, together with the RDY rise.
- A start asserted on the same edge that RDY rises (the FIX edge) takes priority: FIX is aborted, no RDY is produced, and the new operation begins.
- Back-to-back throughput: a start on edge WIDTH+2 (the RDY cycle) is legal and begins a new operation while RDY is high.
- Reset mid-operation: the next valid start follows the normal timing, with no residual RDY.

## Configuration
- MULTDIV_HI_EN defined: data_result_hi carries the product high half P[2*WIDTH-1:WIDTH] for multiply and the remainder for divide. Its register, and the remainder sign fix, are built in.
- MULTDIV_HI_EN undefined: data_result_hi is constant 0 and the high-half register is removed. data_result, data_exception and timing are unchanged.

## Test plan
- WIDTH=32, A=2, B=-4, one-cycle ctrl_MULT -> RDY exactly 33 cycles after the start edge. data_result=32'hFFFFFFF8, exception=0, result_hi=32'hFFFFFFFF (with _EN).
- WIDTH=32, A=32'h00010000, B=32'h00010000, MULT -> data_result=0, exception=1, result_hi=1 (with _EN).
- WIDTH=32, A=-7, B=2, DIV -> data_result=-3, exception=0, result_hi=-1 (with _EN). Then A=5, B=0, DIV -> data_result=0, exception=1.
- WIDTH=8, A=8'h80, B=8'hFF, DIV -> data_result=8'h80, exception=1. Then A=8'h80, B=8'hFF, MULT -> data_result=8'h80, exception=1, RDY 9 cycles after start.
- WIDTH=32, MULT 3*5, then 10 cycles later DIV 100/7 -> exactly one RDY pulse, 33 cycles after the DIV start, with data_result=14 and result_hi=2 (with _EN). Both ctrl lines high for one edge mid-run -> no effect.
- WIDTH=32, MULT started, reset_n low for 1 cycle at cycle 12 -> all outputs 0 immediately, no RDY. Then MULT 2*-4 -> data_result=-8 after 33 cycles.
